axi_rd_ram_bridge: RTL and testbench
====================================

// Module: axi_rd_ram_bridge
// PURPOSE
//  AXI4 read-channel slave that turns AR bursts into word reads on a simple RAM read port (ren/addr -> data, fixed 1-cycle latency).
//  Returns the words as R beats through a 3-entry output buffer.
//  It is the requester for the mm2s RAM-port model the system bench services, one instance per mm2s port inside top_ram.
// PARAMETERS
//  AXI_WIDTH          128  data width, bits (power of 2, >=32)
//  AXI_ADDR_WIDTH     32   byte address width
//  AXI_ID_WIDTH       6    ARID/RID width
//  AXI_MAX_BURST_LEN  32   max legal beats/burst; longer bursts are errored
//  LSB                $clog2(AXI_WIDTH)-3  derived: byte-offset bits per word
// PORTS
//  clk            in   1                  clock
//  rst            in   1                  synchronous reset, active-high
//  s_axi_arid     in   AXI_ID_WIDTH       burst ID
//  s_axi_araddr   in   AXI_ADDR_WIDTH     start byte address
//  s_axi_arlen    in   8                  beats-1
//  s_axi_arsize   in   3                  bytes/beat log2
//  s_axi_arburst  in   2                  0 FIXED, 1 INCR, 2 WRAP
//  s_axi_arvalid  in   1                  AR valid
//  s_axi_arready  out  1                  AR ready
//  s_axi_rid      out  AXI_ID_WIDTH       beat ID
//  s_axi_rdata    out  AXI_WIDTH          beat data
//  s_axi_rresp    out  2                  0 OKAY, 2 SLVERR
//  s_axi_rlast    out  1                  last beat of burst
//  s_axi_rvalid   out  1                  R valid
//  s_axi_rready   in   1                  R ready
//  ram_ren        out  1                  RAM read strobe
//  ram_addr       out  AXI_ADDR_WIDTH-LSB RAM word address
//  ram_data       in   AXI_WIDTH          RAM data, valid the cycle after ram_ren
// BEHAVIOUR
//  Reset: all outputs 0 while rst=1 (arready, rvalid, ram_ren, ram_addr, rid, rdata, rresp, rlast).
//    Reset flushes state, buffer and in-flight tag. In-flight RAM data is discarded.
//    Reset mid-burst abandons the burst; no further beats are returned.
//  FSM IDLE/BURST.
//    IDLE: arready=1 (from the cycle after rst deasserts).
//    AR handshake: latch id, waddr=araddr>>LSB (low LSB bits ignored), remaining=arlen+1, burst type, err flag.
//      Go to BURST.
//  err = (arsize!=LSB) | (arburst==WRAP or 3) | (arlen+1>AXI_MAX_BURST_LEN).
//    All beats of an errored burst carry rresp=SLVERR.
//    Errored bursts still read RAM and return exactly arlen+1 beats. WRAP/3 addressing behaves as INCR.
//  BURST: ram_ren = (buf_count + inflight) < 3.
//    ram_ren and ram_addr depend only on registered state; no combinational path from AXI inputs.
//    Each ren: INCR waddr+1 (mod 2^(AXI_ADDR_WIDTH-LSB), silent wrap); FIXED waddr unchanged; remaining-1.
//    ren with remaining==1 -> IDLE next cycle; the next AR may be accepted while earlier beats drain.
//  In-flight tag {id,resp,last} is registered with each ren.
//    Next cycle, ram_data plus the tag is pushed into the FIFO at the clock edge.
//  Output FIFO: 3 entries, registered head drives R.
//    Pop on rvalid&rready. Push and pop in the same cycle are allowed.
//    Credit rule guarantees no overflow; the bench checks overflow as an assertion.
//  Latency: AR handshake at edge E0 -> ram_ren during the following cycle -> first rvalid after E0+2 cycles.
//  Throughput: 1 beat/cycle with rready held high.
//  R outputs hold stable while rvalid&!rready (AXI rule). Beats are returned in AR acceptance order.
//  rid, rresp and rlast travel per beat, so overlapping bursts keep their own tags.
// TESTING  (AXI_WIDTH=128, LSB=4, RAM model: mem[a]={4{a}})
//  1 Single beat: araddr=0x100, arlen=0, INCR, rready=1
//      -> one ren, ram_addr=0x10.
//      -> rvalid 2 cycles after AR; rdata={4{32'h10}}, rlast=1, rresp=0, rid=arid.
//  2 INCR: araddr=0x1000, arlen=7, rready=1
//      -> ram_addr 0x100..0x107 on consecutive cycles.
//      -> 8 back-to-back beats; rlast only on beat 8.
//  3 Backpressure: arlen=31, rready random 50%
//      -> 32 beats in order, none lost or duplicated, R stable while stalled, buf_count+inflight never >3.
//  4 FIXED: araddr=0x200, arlen=3 -> ram_addr=0x20 four times; four identical beats, OKAY.
//  5 Errors: arlen=63 -> 64 beats, all SLVERR, rlast on 64th.
//      arsize=2, arlen=0 -> 1 beat with SLVERR.
//  6 Reset and overlap: rst for 1 cycle after 3 beats of an arlen=7 burst -> rvalid=0 next cycle, arready=1 after release.
//      Then two ARs back-to-back, id 5 then id 9 -> all id-5 beats precede id-9 beats with correct rlast.

Source files
------------

// File: rtl/axi_rd_ram_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_ram_bridge_if
//  Description : Bus bundle for axi_rd_ram_bridge. It carries the AXI4 read
//                address (AR) channel, the read data (R) channel and the
//                simple word-read RAM port (ren/addr -> data, 1-cycle
//                latency).
//                modport slave  : bridge side (AXI slave, RAM requester)
//                modport master : AXI master + RAM model side
//  Revision    : 1.0  initial release
// ============================================================================
interface axi_rd_ram_bridge_if #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6
);
  localparam int LSB = $clog2(AXI_WIDTH) - 3;

  // AR channel
  logic [AXI_ID_WIDTH-1:0]       s_axi_arid;
  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr;
  logic [7:0]                    s_axi_arlen;
  logic [2:0]                    s_axi_arsize;
  logic [1:0]                    s_axi_arburst;
  logic                          s_axi_arvalid;
  logic                          s_axi_arready;
  // R channel
  logic [AXI_ID_WIDTH-1:0]       s_axi_rid;
  logic [AXI_WIDTH-1:0]          s_axi_rdata;
  logic [1:0]                    s_axi_rresp;
  logic                          s_axi_rlast;
  logic                          s_axi_rvalid;
  logic                          s_axi_rready;
  // RAM read port
  logic                          ram_ren;
  logic [AXI_ADDR_WIDTH-LSB-1:0] ram_addr;
  logic [AXI_WIDTH-1:0]          ram_data;

  modport slave (
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arvalid, s_axi_rready, ram_data,
    output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_rvalid, ram_ren, ram_addr
  );

  modport master (
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
           s_axi_arvalid, s_axi_rready, ram_data,
    input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
           s_axi_rvalid, ram_ren, ram_addr
  );
endinterface
`default_nettype wire

// File: rtl/axi_rd_ram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_ram_bridge
//  Description : AXI4 read-channel slave. Each AR burst becomes a series of
//                word reads on a 1-cycle-latency RAM port; the returned words
//                go out as R beats through a 3-entry output buffer.
//  Ports       : clk  - clock
//                rst  - synchronous reset, active-high
//                bus  - axi_rd_ram_bridge_if.slave (AR, R, RAM port)
//  Revision    : 1.0  initial release
// ============================================================================
module axi_rd_ram_bridge #(
  parameter int AXI_WIDTH         = 128,
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 6,
  parameter int AXI_MAX_BURST_LEN = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_rd_ram_bridge_if.slave      bus
);
  localparam int         LSB       = $clog2(AXI_WIDTH) - 3;
  localparam int         c_WA      = AXI_ADDR_WIDTH - LSB;
  localparam int         c_DEPTH   = 3;
  localparam logic [2:0] c_SIZE    = 3'(LSB);
  localparam logic [9:0] c_MAX_LEN = 10'(AXI_MAX_BURST_LEN);
  localparam logic [1:0] c_OKAY    = 2'b00;
  localparam logic [1:0] c_SLVERR  = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  // Burst sequencer
  state_t                  r_state;
  logic                    r_arready;
  logic [AXI_ID_WIDTH-1:0] r_id;
  logic [c_WA-1:0]         r_waddr;
  logic [8:0]              r_remaining;
  logic                    r_fixed;
  logic                    r_err;

  // Tag of the RAM read issued last cycle; its data arrives this cycle
  logic                    r_inflight;
  logic [AXI_ID_WIDTH-1:0] r_tag_id;
  logic [1:0]              r_tag_resp;
  logic                    r_tag_last;

  // Output buffer, slot 0 is the head driving R
  logic [AXI_WIDTH-1:0]    r_fdata [c_DEPTH];
  logic [AXI_ID_WIDTH-1:0] r_fid   [c_DEPTH];
  logic [1:0]              r_fresp [c_DEPTH];
  logic                    r_flast [c_DEPTH];
  logic [1:0]              r_count;

  logic                    w_ar_hs;
  logic [9:0]              w_ar_beats;
  logic                    w_ar_err;
  logic                    w_ren;
  logic                    w_push;
  logic                    w_pop;
  logic [1:0]              w_wr_idx;

  assign w_ar_hs    = bus.s_axi_arvalid & r_arready;
  assign w_ar_beats = {2'b00, bus.s_axi_arlen} + 10'd1;
  // WRAP (2) and reserved (3) both have arburst[1] set
  assign w_ar_err   = (bus.s_axi_arsize != c_SIZE) | bus.s_axi_arburst[1] |
                      (w_ar_beats > c_MAX_LEN);

  // Credit: words already buffered plus the one in flight must leave room,
  // so the buffer can never overflow. Only registered state feeds this.
  assign w_ren    = (r_state == S_BURST) &&
                    (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd3);
  assign w_push   = r_inflight;
  assign w_pop    = (r_count != 2'd0) & bus.s_axi_rready;
  // On a simultaneous pop the buffer shifts down, so the new word lands one slot lower
  assign w_wr_idx = r_count - {1'b0, w_pop};

  // --------------------------------------------------------------------------
  // Burst sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_arready   <= 1'b0;
      r_id        <= '0;
      r_waddr     <= '0;
      r_remaining <= '0;
      r_fixed     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_id        <= bus.s_axi_arid;
            r_waddr     <= bus.s_axi_araddr[AXI_ADDR_WIDTH-1:LSB];
            r_remaining <= w_ar_beats[8:0];
            r_fixed     <= (bus.s_axi_arburst == 2'b00);
            r_err       <= w_ar_err;
            r_arready   <= 1'b0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_ren) begin
            if (!r_fixed) begin
              r_waddr <= r_waddr + 1'b1;
            end
            r_remaining <= r_remaining - 9'd1;
            if (r_remaining == 9'd1) begin
              r_state   <= S_IDLE;
              r_arready <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_arready <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // In-flight tag and output buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_tag_id   <= '0;
      r_tag_resp <= c_OKAY;
      r_tag_last <= 1'b0;
      r_count    <= 2'd0;
      for (int i = 0; i < c_DEPTH; i++) begin
        r_fdata[i] <= '0;
        r_fid[i]   <= '0;
        r_fresp[i] <= c_OKAY;
        r_flast[i] <= 1'b0;
      end
    end else begin
      r_inflight <= w_ren;
      if (w_ren) begin
        r_tag_id   <= r_id;
        r_tag_resp <= r_err ? c_SLVERR : c_OKAY;
        r_tag_last <= (r_remaining == 9'd1);
      end

      for (int i = 0; i < c_DEPTH - 1; i++) begin
        if (w_push && (w_wr_idx == 2'(i))) begin
          r_fdata[i] <= bus.ram_data;
          r_fid[i]   <= r_tag_id;
          r_fresp[i] <= r_tag_resp;
          r_flast[i] <= r_tag_last;
        end else if (w_pop) begin
          r_fdata[i] <= r_fdata[i+1];
          r_fid[i]   <= r_fid[i+1];
          r_fresp[i] <= r_fresp[i+1];
          r_flast[i] <= r_flast[i+1];
        end
      end
      if (w_push && (w_wr_idx == 2'(c_DEPTH - 1))) begin
        r_fdata[c_DEPTH-1] <= bus.ram_data;
        r_fid[c_DEPTH-1]   <= r_tag_id;
        r_fresp[c_DEPTH-1] <= r_tag_resp;
        r_flast[c_DEPTH-1] <= r_tag_last;
      end

      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: forced to zero while reset is asserted
  // --------------------------------------------------------------------------
  assign bus.s_axi_arready = r_arready & ~rst;
  assign bus.s_axi_rvalid  = (r_count != 2'd0) & ~rst;
  assign bus.s_axi_rid     = rst ? '0 : r_fid[0];
  assign bus.s_axi_rdata   = rst ? '0 : r_fdata[0];
  assign bus.s_axi_rresp   = rst ? c_OKAY : r_fresp[0];
  assign bus.s_axi_rlast   = r_flast[0] & ~rst;
  assign bus.ram_ren       = w_ren & ~rst;
  assign bus.ram_addr      = rst ? '0 : r_waddr;
endmodule
`default_nettype wire

// File: tb/tb_axi_rd_ram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_rd_ram_bridge
//  Description : Self-checking bench for axi_rd_ram_bridge. A queue model
//                expands each accepted AR into its expected RAM word addresses
//                and R beats; monitors compare the DUT against it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_rd_ram_bridge;
  localparam int W    = 128;
  localparam int AW   = 32;
  localparam int IW   = 6;
  localparam int MAXB = 32;
  localparam int LSB  = 4;

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_rd_ram_bridge_if #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) bus ();

  axi_rd_ram_bridge #(
    .AXI_WIDTH(W), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_MAX_BURST_LEN(MAXB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int beats_seen  = 0;
  int outstanding = 0;

  beat_t            exp_q[$];
  logic [AW-LSB-1:0] addr_q[$];

  bit rr_rand  = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: RAM holds mem[a] = {4{a}}; the burst is expanded by the rules.
  task automatic model_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [AW-LSB-1:0] a0;
    logic [AW-LSB-1:0] wa;
    logic              err;
    beat_t             b;
    a0  = addr[AW-1:LSB];
    err = (size != 3'(LSB)) || (burst >= 2'd2) || (int'(len) + 1 > MAXB);
    for (int k = 0; k <= int'(len); k++) begin
      wa = (burst == 2'd0) ? a0 : a0 + (AW-LSB)'(k);
      addr_q.push_back(wa);
      b.id   = id;
      b.data = {4{{4'h0, wa}}};
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (k == int'(len));
      exp_q.push_back(b);
    end
  endtask

  // RAM model: data valid the cycle after ren; garbage otherwise
  always @(posedge clk) begin
    if (bus.ram_ren) bus.ram_data <= {4{{4'h0, bus.ram_addr}}};
    else             bus.ram_data <= {$urandom, $urandom, $urandom, $urandom};
  end

  // rready driver
  initial begin
    bus.s_axi_rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.s_axi_rready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitors: RAM address order, credit bound, R stability, R beat contents
  logic          prev_stall = 1'b0;
  logic [IW-1:0] prev_id;
  logic [W-1:0]  prev_data;
  logic [1:0]    prev_resp;
  logic          prev_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      chk("credit_le3", W'(outstanding <= 3), W'(1));
      if (bus.ram_ren) begin
        chk("ren_expected", W'(addr_q.size() > 0), W'(1));
        if (addr_q.size() > 0) chk("ram_addr", W'(bus.ram_addr), W'(addr_q.pop_front()));
        outstanding++;
      end
      if (prev_stall) begin
        chk("stall_rvalid", W'(bus.s_axi_rvalid), W'(1));
        chk("stall_rdata", bus.s_axi_rdata, prev_data);
        chk("stall_rid", W'(bus.s_axi_rid), W'(prev_id));
        chk("stall_rresp", W'(bus.s_axi_rresp), W'(prev_resp));
        chk("stall_rlast", W'(bus.s_axi_rlast), W'(prev_last));
      end
      if (bus.s_axi_rvalid && bus.s_axi_rready) begin
        chk("beat_expected", W'(exp_q.size() > 0), W'(1));
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          chk("rid", W'(bus.s_axi_rid), W'(e.id));
          chk("rdata", bus.s_axi_rdata, e.data);
          chk("rresp", W'(bus.s_axi_rresp), W'(e.resp));
          chk("rlast", W'(bus.s_axi_rlast), W'(e.last));
        end
        beats_seen++;
        outstanding--;
      end
      prev_stall = bus.s_axi_rvalid & ~bus.s_axi_rready;
      prev_id    = bus.s_axi_rid;
      prev_data  = bus.s_axi_rdata;
      prev_resp  = bus.s_axi_rresp;
      prev_last  = bus.s_axi_rlast;
    end
  end

  // Present one AR, wait (bounded) for acceptance, record it in the model
  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n;
    bit ok;
    @(posedge clk);
    #1;
    bus.s_axi_arid    = id;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arlen   = len;
    bus.s_axi_arsize  = size;
    bus.s_axi_arburst = burst;
    bus.s_axi_arvalid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 3000) begin
      @(negedge clk);
      if (bus.s_axi_arready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      chk("ar_accept", W'(bus.s_axi_arready), W'(1));
    end else begin
      @(posedge clk);
      model_ar(id, addr, len, size, burst);
    end
    #1;
    bus.s_axi_arvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, W'(exp_q.size() + addr_q.size()), W'(0));
    repeat (2) @(negedge clk);
    chk({tag, "_idle_rvalid"}, W'(bus.s_axi_rvalid), W'(0));
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int start;
    int n;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_arid    = '0;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arlen   = '0;
    bus.s_axi_arsize  = '0;
    bus.s_axi_arburst = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_arready", W'(bus.s_axi_arready), W'(0));
    chk("rst_rvalid", W'(bus.s_axi_rvalid), W'(0));
    chk("rst_ram_ren", W'(bus.ram_ren), W'(0));
    chk("rst_ram_addr", W'(bus.ram_addr), W'(0));
    chk("rst_rid", W'(bus.s_axi_rid), W'(0));
    chk("rst_rdata", bus.s_axi_rdata, W'(0));
    chk("rst_rresp", W'(bus.s_axi_rresp), W'(0));
    chk("rst_rlast", W'(bus.s_axi_rlast), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_arready", W'(bus.s_axi_arready), W'(1));

    // 1: single beat, latency
    send_ar(6'd3, 32'h100, 8'd0, 3'd4, 2'd1);
    @(negedge clk);
    chk("t1_ren", W'(bus.ram_ren), W'(1));
    chk("t1_ram_addr", W'(bus.ram_addr), W'(28'h10));
    chk("t1_rvalid_e0", W'(bus.s_axi_rvalid), W'(0));
    @(negedge clk);
    chk("t1_rvalid_e1", W'(bus.s_axi_rvalid), W'(0));
    @(negedge clk);
    chk("t1_rvalid_e2", W'(bus.s_axi_rvalid), W'(1));
    chk("t1_rdata", bus.s_axi_rdata, {4{32'h10}});
    chk("t1_rlast", W'(bus.s_axi_rlast), W'(1));
    chk("t1_rid", W'(bus.s_axi_rid), W'(3));
    drain("t1_drain");

    // 2: INCR back-to-back timing
    send_ar(6'd7, 32'h1000, 8'd7, 3'd4, 2'd1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk("t2_ren", W'(bus.ram_ren), W'(k <= 8));
      chk("t2_rvalid", W'(bus.s_axi_rvalid), W'(k >= 3 && k <= 10));
      chk("t2_rlast", W'(bus.s_axi_rlast), W'(k == 10));
    end
    drain("t2_drain");

    // 3: 32 beats under random backpressure
    rr_rand = 1'b1;
    send_ar(6'd11, 32'h4000, 8'd31, 3'd4, 2'd1);
    drain("t3_drain");

    // 4: FIXED
    rr_rand = 1'b0;
    send_ar(6'd2, 32'h200, 8'd3, 3'd4, 2'd0);
    drain("t4_drain");

    // 5: errored bursts (too long, bad size, WRAP) and address wrap at the top
    rr_rand = 1'b1;
    send_ar(6'd4, 32'h800, 8'd63, 3'd4, 2'd1);
    drain("t5_long");
    send_ar(6'd1, 32'h300, 8'd0, 3'd2, 2'd1);
    send_ar(6'd12, 32'h340, 8'd3, 3'd4, 2'd2);
    send_ar(6'd13, 32'hFFFF_FFE0, 8'd3, 3'd4, 2'd1);
    drain("t5_misc");

    // 6: reset mid-burst, then overlapping bursts
    rr_rand = 1'b0;
    start = beats_seen;
    send_ar(6'd6, 32'h500, 8'd7, 3'd4, 2'd1);
    n = 0;
    while (beats_seen - start < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_three_beats", W'(beats_seen - start), W'(3));
    do_reset(1);
    @(negedge clk);
    chk("t6_rvalid_after_rst", W'(bus.s_axi_rvalid), W'(0));
    chk("t6_ren_after_rst", W'(bus.ram_ren), W'(0));
    repeat (2) @(negedge clk);
    chk("t6_arready", W'(bus.s_axi_arready), W'(1));
    chk("t6_no_beats", W'(bus.s_axi_rvalid), W'(0));
    send_ar(6'd5, 32'h600, 8'd3, 3'd4, 2'd1);
    send_ar(6'd9, 32'h700, 8'd5, 3'd4, 2'd1);
    drain("t6_overlap");

    // Random bursts, overlapped, random backpressure
    rr_rand = 1'b1;
    for (int r = 0; r < 20; r++) begin
      send_ar(IW'($urandom), $urandom, 8'($urandom_range(0, 40)),
              ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd4,
              2'($urandom_range(0, 3)));
    end
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
